// File: rtl/mult_booth_dot_accum_pkg.sv
// Shared types and width helpers for the Booth multiplier dot-product stage.
// The accumulator width is derived here so upstream stages can use the same value.
package mult_booth_dot_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Wide enough to sum len full-scale products without overflow.
  function automatic int acc_width(input int data_width, input int len);
    return 2 * data_width + clog2(len);
  endfunction

endpackage

// File: rtl/mult_booth_accum_ctrl.sv
// Sequencing for the dot-product stage: IDLE/ACCUM/HOLD FSM, product counter,
// input-ready generation and load/add/commit strobes for the datapath.
module mult_booth_accum_ctrl
  import mult_booth_dot_accum_pkg::*;
#(
  parameter int ACC_LEN   = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 load,
  output logic                 add,
  output logic                 commit,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] LAST   = CNT_WIDTH'(ACC_LEN - 1);
  localparam logic                 SINGLE = (ACC_LEN == 1);

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic                   accept, take, last_beat;

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  // With a single product per result every accept completes a sum.
  assign last_beat = SINGLE | ((state == ST_ACCUM) && (count_reg == LAST));
  assign count     = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state     <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count_reg;
    if (clr) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else if (accept) begin
      if (last_beat) begin
        state_next = ST_HOLD;
        count_next = '0;
      end else if (state == ST_ACCUM) begin
        count_next = count_reg + CNT_WIDTH'(1);
      end else begin
        state_next = ST_ACCUM;
        count_next = CNT_WIDTH'(1);
      end
    end else if (take) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    load   = accept & ~clr & (state != ST_ACCUM);
    add    = accept & ~clr & (state == ST_ACCUM);
    commit = accept & ~clr & last_beat;
  end

endmodule

// File: rtl/mult_booth_dot_accum.sv
// Dot-product accumulator behind the Booth multiplier: sums ACC_LEN signed
// products and hands the result out over a valid/ready interface.
module mult_booth_dot_accum
  import mult_booth_dot_accum_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int ACC_LEN    = 4,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, ACC_LEN),
  localparam int CNT_WIDTH  = clog2(ACC_LEN + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [2*DATA_WIDTH-1:0] iv_prod,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [ACC_WIDTH-1:0]    ov_acc,
  output logic [CNT_WIDTH-1:0]    ov_count
);

  generate
    if (ACC_LEN < 1) begin : g_bad_len
      $error("mult_booth_dot_accum: ACC_LEN must be at least 1");
    end
  endgenerate

  logic                        load, add, commit;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;

  assign prod_ext = ACC_WIDTH'(signed'(iv_prod));
  assign ov_acc   = acc_reg;

  mult_booth_accum_ctrl #(
    .ACC_LEN   (ACC_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clr       (i_clr),
    .in_valid  (i_in_valid),
    .out_ready (i_out_ready),
    .in_ready  (o_in_ready),
    .out_valid (o_out_valid),
    .load      (load),
    .add       (add),
    .commit    (commit),
    .count     (ov_count)
  );

  // ov_acc is deliberately untouched by clr; o_out_valid alone qualifies it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_reg <= '0;
      acc_reg <= '0;
    end else begin
      if (i_clr) begin
        sum_reg <= '0;
      end else if (commit) begin
        sum_reg <= '0;
      end else if (load) begin
        sum_reg <= prod_ext;
      end else if (add) begin
        sum_reg <= sum_reg + prod_ext;
      end
      if (commit) begin
        acc_reg <= (add ? sum_reg : '0) + prod_ext;
      end
    end
  end

endmodule
